glyph_plotter: RTL

//  Serialises one 8x16 glyph bitmap from char_decoder into per-pixel writes for the
//  VGA adapter framebuffer. It latches a 128-bit glyph, a character cell (col,row) and

---
 rtl/glyph_plotter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/glyph_plotter.sv
// rtl/glyph_plotter.sv - serialises an 8x16 glyph bitmap into per-pixel framebuffer writes
module glyph_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int COLS     = 20,
    parameter int ROWS     = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [127:0]        glyph,
    input  logic [4:0]          cell_col,
    input  logic [2:0]          cell_row,
    input  logic [COLOUR_W-1:0] fg,
    input  logic [COLOUR_W-1:0] bg,
    input  logic                transp,
    input  logic                stall,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t              state;
    logic [127:0]        glyph_q;
    logic [4:0]          col_q;
    logic [2:0]          row_q;
    logic [COLOUR_W-1:0] fg_q;
    logic [COLOUR_W-1:0] bg_q;
    logic                transp_q;
    logic [6:0]          idx;

    // Next pixel to present: pixel 0 straight from the inputs on start, else idx+1 from the latch.
    logic [6:0]          s_idx;
    logic [127:0]        s_glyph;
    logic [4:0]          s_col;
    logic [2:0]          s_row;
    logic [COLOUR_W-1:0] s_fg;
    logic [COLOUR_W-1:0] s_bg;
    logic                s_transp;
    logic                s_bit;
    logic [X_W-1:0]      x_n;
    logic [Y_W-1:0]      y_n;
    logic                bad_cell;

    always_comb begin
        s_idx    = 7'd0;
        s_glyph  = glyph;
        s_col    = cell_col;
        s_row    = cell_row;
        s_fg     = fg;
        s_bg     = bg;
        s_transp = transp;
        if (state == DRAW) begin
            s_idx    = idx + 7'd1;
            s_glyph  = glyph_q;
            s_col    = col_q;
            s_row    = row_q;
            s_fg     = fg_q;
            s_bg     = bg_q;
            s_transp = transp_q;
        end
        s_bit    = s_glyph[7'd127 - s_idx];
        x_n      = X_W'(32'(s_col) * 8 + 32'(s_idx[2:0]));
        y_n      = Y_W'(32'(s_row) * 16 + 32'(s_idx[6:3]));
        bad_cell = (32'(cell_col) >= COLS) || (32'(cell_row) >= ROWS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            glyph_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            transp_q <= 1'b0;
            idx      <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                // The done cycle also accepts a new start so consecutive glyphs run back to back.
                IDLE, FIN: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        glyph_q  <= glyph;
                        col_q    <= cell_col;
                        row_q    <= cell_row;
                        fg_q     <= fg;
                        bg_q     <= bg;
                        transp_q <= transp;
                        idx      <= '0;
                        if (bad_cell) begin
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state  <= DRAW;
                            busy   <= 1'b1;
                            x      <= x_n;
                            y      <= y_n;
                            colour <= s_bit ? s_fg : s_bg;
                            plot   <= s_bit | ~s_transp;
                        end
                    end
                end
                DRAW: begin
                    if (!stall) begin
                        if (idx == 7'd127) begin
                            state <= FIN;
                            plot  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx    <= s_idx;
                            x      <= x_n;
                            y      <= y_n;
                            colour <= s_bit ? s_fg : s_bg;
                            plot   <= s_bit | ~s_transp;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
